// File: rtl/adc_spi_reader.sv
// ---------------------------------------------------------------------------
// adc_spi_reader
//
// Reads one sample out of a serial ADC each time the conversion trigger
// block reports a finished conversion. The sample is sign-extended to
// 32 bits and presented on an AXI-Stream master. Words are grouped into
// packets with tlast. A ready/last handshake goes back to the trigger
// block so that it can throttle conversions.
//
// Parameters:
//   DATA_WIDTH    ADC sample width in bits (2..32)
//   SCK_HALF      SCK half-period in clk cycles (>= 1)
//
// Ports:
//   clk            system clock
//   resetn         synchronous active-low reset
//   trigger        one-cycle pulse: conversion finished, start readout
//   packet_len     words per packet, 0 = unframed (tlast never set)
//   clear_overrun  one-cycle pulse that clears the sticky overrun flag
//   sck            serial clock to the ADC
//   cs_n           ADC chip select, active low
//   sdo            ADC serial data, MSB first
//   m_axis_tdata   sign-extended sample
//   m_axis_tvalid  AXI-Stream valid
//   m_axis_tready  AXI-Stream ready
//   m_axis_tlast   last word of the packet
//   ready          to trigger block: able to accept the next trigger
//   last           to trigger block: pulse after the final word of a packet
//   overrun        sticky: a trigger arrived while the reader was busy
// ---------------------------------------------------------------------------
module adc_spi_reader #(
    parameter int DATA_WIDTH = 24,
    parameter int SCK_HALF   = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        trigger,
    input  logic [31:0] packet_len,
    input  logic        clear_overrun,
    output logic        sck,
    output logic        cs_n,
    input  logic        sdo,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        ready,
    output logic        last,
    output logic        overrun
);

    localparam int HC_W = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
    localparam int BC_W = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_t;

    state_t state, next_state;

    logic [HC_W-1:0]       half_cnt;
    logic [BC_W-1:0]       bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [31:0]           word_cnt;
    logic [31:0]           plen_q;
    logic [31:0]           tdata_q;
    logic                  sck_q;
    logic                  cs_n_q;
    logic                  last_q;
    logic                  overrun_q;

    logic                  half_end;
    logic                  shift_done;
    logic                  xfer;
    logic                  tlast_c;

    // Shift timing, stream handshake, and the next-state decision.
    // shift_done marks the final cycle of the last high half-period.
    always_comb begin
        half_end   = (half_cnt == HC_W'(SCK_HALF - 1));
        shift_done = (state == SHIFT) && half_end && sck_q && (bit_cnt == '0);
        xfer       = (state == HOLD) && m_axis_tready;
        tlast_c    = (state == HOLD) && (plen_q != 32'd0) &&
                     (word_cnt == plen_q - 32'd1);

        next_state = state;
        case (state)
            IDLE:    if (trigger)    next_state = SHIFT;
            SHIFT:   if (shift_done) next_state = HOLD;
            HOLD:    if (xfer)       next_state = IDLE;
            default:                 next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= next_state;
    end

    // Serial datapath, framing counter and sticky flags.
    // A trigger outside IDLE never touches the datapath; it only sets
    // overrun, and setting takes priority over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            half_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            word_cnt  <= '0;
            plen_q    <= '0;
            tdata_q   <= '0;
            sck_q     <= 1'b0;
            cs_n_q    <= 1'b1;
            last_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            last_q <= xfer && tlast_c;

            if (trigger && (state != IDLE))
                overrun_q <= 1'b1;
            else if (clear_overrun)
                overrun_q <= 1'b0;

            if (xfer)
                word_cnt <= tlast_c ? 32'd0 : word_cnt + 32'd1;

            case (state)
                IDLE: begin
                    if (trigger) begin
                        cs_n_q   <= 1'b0;
                        sck_q    <= 1'b0;
                        half_cnt <= '0;
                        bit_cnt  <= BC_W'(DATA_WIDTH - 1);
                    end
                end
                SHIFT: begin
                    if (!half_end) begin
                        half_cnt <= half_cnt + 1'b1;
                    end else begin
                        half_cnt <= '0;
                        if (!sck_q) begin
                            // sdo is captured on the edge that raises sck.
                            sck_q     <= 1'b1;
                            shift_reg <= {shift_reg[DATA_WIDTH-2:0], sdo};
                        end else begin
                            sck_q <= 1'b0;
                            if (shift_done) begin
                                cs_n_q  <= 1'b1;
                                tdata_q <= 32'($signed(shift_reg));
                                plen_q  <= packet_len;
                            end else begin
                                bit_cnt <= bit_cnt - 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign sck           = sck_q;
    assign cs_n          = cs_n_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = (state == HOLD);
    assign m_axis_tlast  = tlast_c;
    assign ready         = (state == IDLE) && resetn;
    assign last          = last_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_adc_spi_reader.sv
// ---------------------------------------------------------------------------
// tb_adc_spi_reader
//
// Directed bench for adc_spi_reader with default parameters. A small ADC
// model shifts a chosen 24-bit word onto sdo, MSB first. It presents the
// first bit when cs_n falls and each following bit on a falling sck edge.
// ---------------------------------------------------------------------------
module tb_adc_spi_reader;

    logic        clk = 1'b0;
    logic        resetn;
    logic        trigger;
    logic [31:0] packet_len;
    logic        clear_overrun;
    logic        sck;
    logic        cs_n;
    logic        sdo;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        ready;
    logic        last;
    logic        overrun;

    int total = 0;
    int bad   = 0;

    logic [23:0] adc_word = 24'h0;
    int          adc_idx  = 0;
    int          sck_rises = 0;

    adc_spi_reader #(.DATA_WIDTH(24), .SCK_HALF(2)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .trigger       (trigger),
        .packet_len    (packet_len),
        .clear_overrun (clear_overrun),
        .sck           (sck),
        .cs_n          (cs_n),
        .sdo           (sdo),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .ready         (ready),
        .last          (last),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    // ADC model: first bit on cs_n fall, next bits on sck falling edges.
    initial sdo = 1'b0;

    always @(negedge cs_n) begin
        adc_idx = 23;
        sdo     = adc_word[23];
    end

    always @(negedge sck) begin
        if (cs_n === 1'b0) begin
            adc_idx = adc_idx - 1;
            if (adc_idx >= 0) sdo = adc_word[adc_idx];
        end
    end

    always @(posedge sck) begin
        if (cs_n === 1'b0) sck_rises = sck_rises + 1;
    end

    // Advance n clock edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        step(2);
        resetn = 1'b1;
        step(1);
    endtask

    // Triggers one conversion (trigger is high in cycle 0). An optional
    // second trigger pulse can be placed at cycle inject_at. The task returns
    // in the first cycle in which tvalid is high, or returns lat=-1 on timeout.
    task automatic run_word(input logic [23:0] w, input int inject_at,
                            output logic [31:0] d, output logic tl,
                            output int lat);
        adc_word = w;
        lat      = -1;
        d        = 32'h0;
        tl       = 1'b0;
        trigger  = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            trigger = (c == inject_at);
            if (m_axis_tvalid === 1'b1) begin
                lat = c;
                d   = m_axis_tdata;
                tl  = m_axis_tlast;
                break;
            end
        end
        trigger = 1'b0;
    endtask

    task automatic test_reset();
        resetn        = 1'b0;
        trigger       = 1'b0;
        clear_overrun = 1'b0;
        packet_len    = 32'd0;
        m_axis_tready = 1'b1;
        step(3);
        total++; if (sck !== 1'b0) begin bad++; $display("[TB] FAIL rst_sck got=%b exp=0", sck); end
        total++; if (cs_n !== 1'b1) begin bad++; $display("[TB] FAIL rst_cs_n got=%b exp=1", cs_n); end
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL rst_tvalid got=%b exp=0", m_axis_tvalid); end
        total++; if (m_axis_tlast !== 1'b0) begin bad++; $display("[TB] FAIL rst_tlast got=%b exp=0", m_axis_tlast); end
        total++; if (m_axis_tdata !== 32'h0) begin bad++; $display("[TB] FAIL rst_tdata got=%h exp=0", m_axis_tdata); end
        total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_ready got=%b exp=0", ready); end
        total++; if (last !== 1'b0) begin bad++; $display("[TB] FAIL rst_last got=%b exp=0", last); end
        total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL rst_overrun got=%b exp=0", overrun); end
        resetn = 1'b1;
        step(1);
        total++; if (ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_release_ready got=%b exp=1", ready); end
    endtask

    task automatic test_basic_read();
        int          cs_low = 0;
        int          tv_at  = -1;
        logic        cs_first = 1'b1;
        logic [31:0] d = 32'h0;
        logic        rdy_after = 1'b0;
        logic        tv_after  = 1'b1;
        logic        tl_seen   = 1'b1;
        adc_word  = 24'h123456;
        sck_rises = 0;
        trigger   = 1'b1;
        for (int c = 1; c <= 110; c++) begin
            @(posedge clk);
            #1;
            trigger = 1'b0;
            if (c == 1) cs_first = cs_n;
            if (cs_n === 1'b0) cs_low++;
            if (m_axis_tvalid === 1'b1 && tv_at < 0) begin
                tv_at   = c;
                d       = m_axis_tdata;
                tl_seen = m_axis_tlast;
            end
            if (c == 98) begin
                rdy_after = ready;
                tv_after  = m_axis_tvalid;
            end
        end
        total++; if (cs_first !== 1'b0) begin bad++; $display("[TB] FAIL basic_cs_first got=%b exp=0", cs_first); end
        total++; if (cs_low != 96) begin bad++; $display("[TB] FAIL basic_cs_low_cycles got=%0d exp=96", cs_low); end
        total++; if (sck_rises != 24) begin bad++; $display("[TB] FAIL basic_sck_rises got=%0d exp=24", sck_rises); end
        total++; if (tv_at != 97) begin bad++; $display("[TB] FAIL basic_latency got=%0d exp=97", tv_at); end
        total++; if (d !== 32'h00123456) begin bad++; $display("[TB] FAIL basic_tdata got=%h exp=00123456", d); end
        total++; if (tl_seen !== 1'b0) begin bad++; $display("[TB] FAIL basic_tlast got=%b exp=0", tl_seen); end
        total++; if (rdy_after !== 1'b1) begin bad++; $display("[TB] FAIL basic_ready_after got=%b exp=1", rdy_after); end
        total++; if (tv_after !== 1'b0) begin bad++; $display("[TB] FAIL basic_tvalid_after got=%b exp=0", tv_after); end
    endtask

    task automatic test_negative();
        logic [31:0] d;
        logic        tl;
        int          lat;
        run_word(24'hA5A5A5, 0, d, tl, lat);
        step(1);
        total++; if (lat != 97) begin bad++; $display("[TB] FAIL neg_latency got=%0d exp=97", lat); end
        total++; if (d !== 32'hFFA5A5A5) begin bad++; $display("[TB] FAIL neg_tdata got=%h exp=ffa5a5a5", d); end
    endtask

    task automatic test_framing();
        logic [23:0] words [4] = '{24'h000001, 24'h000002, 24'h000003, 24'h000004};
        logic        exp_tl [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] d;
        logic        tl;
        int          lat;
        apply_reset();
        packet_len    = 32'd3;
        m_axis_tready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            run_word(words[k], 0, d, tl, lat);
            total++; if (d !== {8'h00, words[k]}) begin bad++; $display("[TB] FAIL frame_tdata%0d got=%h exp=%h", k, d, {8'h00, words[k]}); end
            total++; if (tl !== exp_tl[k]) begin bad++; $display("[TB] FAIL frame_tlast%0d got=%b exp=%b", k, tl, exp_tl[k]); end
            step(1);
            total++; if (last !== exp_tl[k]) begin bad++; $display("[TB] FAIL frame_last%0d got=%b exp=%b", k, last, exp_tl[k]); end
            step(1);
            total++; if (last !== 1'b0) begin bad++; $display("[TB] FAIL frame_last_end%0d got=%b exp=0", k, last); end
            step(20);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        logic        tl;
        int          lat;
        apply_reset();
        packet_len    = 32'd2;
        m_axis_tready = 1'b1;
        run_word(24'h111111, 0, d, tl, lat);
        step(2);
        m_axis_tready = 1'b0;
        run_word(24'h654321, 0, d, tl, lat);
        total++; if (d !== 32'h00654321) begin bad++; $display("[TB] FAIL bp_tdata got=%h exp=00654321", d); end
        total++; if (tl !== 1'b1) begin bad++; $display("[TB] FAIL bp_tlast got=%b exp=1", tl); end
        step(5);
        total++; if (m_axis_tvalid !== 1'b1) begin bad++; $display("[TB] FAIL bp_tvalid_hold got=%b exp=1", m_axis_tvalid); end
        total++; if (m_axis_tdata !== 32'h00654321) begin bad++; $display("[TB] FAIL bp_tdata_hold got=%h exp=00654321", m_axis_tdata); end
        total++; if (m_axis_tlast !== 1'b1) begin bad++; $display("[TB] FAIL bp_tlast_hold got=%b exp=1", m_axis_tlast); end
        total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_ready_hold got=%b exp=0", ready); end
        adc_word = 24'hFFFFFF;
        trigger  = 1'b1;
        step(1);
        trigger = 1'b0;
        total++; if (overrun !== 1'b1) begin bad++; $display("[TB] FAIL bp_overrun_set got=%b exp=1", overrun); end
        total++; if (cs_n !== 1'b1) begin bad++; $display("[TB] FAIL bp_no_restart got=%b exp=1", cs_n); end
        step(3);
        total++; if (m_axis_tdata !== 32'h00654321) begin bad++; $display("[TB] FAIL bp_tdata_after_trig got=%h exp=00654321", m_axis_tdata); end
        clear_overrun = 1'b1;
        step(1);
        clear_overrun = 1'b0;
        total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL bp_overrun_clear got=%b exp=0", overrun); end
        m_axis_tready = 1'b1;
        step(1);
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL bp_tvalid_done got=%b exp=0", m_axis_tvalid); end
        total++; if (ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_ready_done got=%b exp=1", ready); end
        total++; if (last !== 1'b1) begin bad++; $display("[TB] FAIL bp_last got=%b exp=1", last); end
        step(2);
    endtask

    task automatic test_trigger_in_shift();
        logic [31:0] d;
        logic        tl;
        int          lat;
        apply_reset();
        packet_len    = 32'd0;
        m_axis_tready = 1'b1;
        // The second pulse lands in cycle 53, where the bit counter is 10.
        run_word(24'h0F1E2D, 53, d, tl, lat);
        step(1);
        total++; if (lat != 97) begin bad++; $display("[TB] FAIL shift_trig_latency got=%0d exp=97", lat); end
        total++; if (d !== 32'h000F1E2D) begin bad++; $display("[TB] FAIL shift_trig_tdata got=%h exp=000f1e2d", d); end
        total++; if (overrun !== 1'b1) begin bad++; $display("[TB] FAIL shift_trig_overrun got=%b exp=1", overrun); end
        total++; if (ready !== 1'b1) begin bad++; $display("[TB] FAIL shift_trig_ready got=%b exp=1", ready); end
    endtask

    task automatic test_reset_mid_shift();
        logic [31:0] d;
        logic        tl;
        int          lat;
        // Overrun stays set from the previous scenario; the reset must clear it.
        // Reset is applied in cycle 47, inside bit 12 while sck is high.
        adc_word = 24'h555555;
        trigger  = 1'b1;
        for (int c = 1; c <= 48; c++) begin
            @(posedge clk);
            #1;
            trigger = 1'b0;
            resetn  = (c != 47);
        end
        total++; if (sck !== 1'b0) begin bad++; $display("[TB] FAIL midrst_sck got=%b exp=0", sck); end
        total++; if (cs_n !== 1'b1) begin bad++; $display("[TB] FAIL midrst_cs_n got=%b exp=1", cs_n); end
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_tvalid got=%b exp=0", m_axis_tvalid); end
        total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL midrst_overrun got=%b exp=0", overrun); end
        step(1);
        total++; if (ready !== 1'b1) begin bad++; $display("[TB] FAIL midrst_ready got=%b exp=1", ready); end
        run_word(24'h7ABCDE, 0, d, tl, lat);
        step(1);
        total++; if (lat != 97) begin bad++; $display("[TB] FAIL midrst_latency got=%0d exp=97", lat); end
        total++; if (d !== 32'h007ABCDE) begin bad++; $display("[TB] FAIL midrst_tdata got=%h exp=007abcde", d); end
    endtask

    initial begin
        $display("[TB] adc_spi_reader bench start");
        test_reset();
        test_basic_read();
        test_negative();
        test_framing();
        test_backpressure();
        test_trigger_in_shift();
        test_reset_mid_shift();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_spi_reader.md
Name: adc_spi_reader

Overview:
- Acquisition-side counterpart to the ADC conversion trigger.
- When `trigger` pulses after a conversion completes, the block clocks one sample out of the ADC serial data output (SDO) and sign-extends it.
- It presents the sample on an AXI-Stream master, with packet framing via `tlast`.
- It drives the `ready` and `last` handshake back to the trigger block, which throttles conversions on downstream back-pressure and packet end.

Parameters:
- DATA_WIDTH, 24, ADC sample width in bits; 2..32.
- SCK_HALF, 2, SCK half-period in clk cycles; ≥1.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous active-low reset.
- trigger  in  1  one-cycle pulse: conversion finished, start readout.
- packet_len  in  32  words per packet; 0 = unframed (tlast never set).
- clear_overrun  in  1  one-cycle pulse, clears overrun.
- sck  out  1  serial clock to ADC.
- cs_n  out  1  ADC chip select, active low.
- sdo  in  1  ADC serial data, MSB first.
- m_axis_tdata  out  32  sign-extended sample.
- m_axis_tvalid  out  1  AXI-Stream valid.
- m_axis_tready  in  1  AXI-Stream ready.
- m_axis_tlast  out  1  last word of packet.
- ready  out  1  to trigger block: able to accept next trigger.
- last  out  1  to trigger block: one-cycle pulse on the final packet word handshake.
- overrun  out  1  sticky: trigger arrived while not ready.

Behaviour:
- Reset (resetn low at a clk edge) overrides everything, including mid-shift:
  - state IDLE; sck=0; cs_n=1.
  - tvalid=0, tlast=0, tdata=0.
  - ready=0 during reset, then 1 the first cycle after reset release.
  - last=0; overrun=0; word counter=0; bit counter=0.
- States:
  - IDLE: waiting for trigger.
  - SHIFT: clocking the sample out of the ADC.
  - HOLD: word presented on the stream, waiting for tready.
- IDLE → SHIFT on trigger=1.
  - cs_n goes low the next cycle.
  - SHIFT lasts exactly 2*SCK_HALF*DATA_WIDTH cycles.
  - Each bit period: SCK_HALF cycles sck=0, then SCK_HALF cycles sck=1.
- Sampling:
  - sdo is sampled on the clk edge at which sck is driven 0→1.
  - Shift is MSB first into a DATA_WIDTH shift register.
  - Bit counter runs DATA_WIDTH-1 down to 0.
- SHIFT → HOLD after the last high half-period:
  - sck=0 and cs_n=1 in the same cycle.
  - tvalid=1 from that cycle.
  - tdata = sample sign-extended to 32 bits (bit DATA_WIDTH-1 replicated).
- HOLD exit:
  - Transfer occurs when tvalid & tready on a clk edge.
  - HOLD → IDLE on the transfer; tvalid drops the next cycle.
  - tdata and tlast are stable while tvalid=1 and tready=0.
- Framing:
  - tlast=1 in HOLD when packet_len≠0 and word counter == packet_len-1.
  - Word counter increments on each transfer and resets to 0 on a transfer with tlast.
  - packet_len is sampled when entering HOLD; changing it mid-packet takes effect at the next word.
  - If packet_len drops below the counter, tlast is not asserted until the 32-bit counter wraps. This is a software error and is not guarded.
- `last` is a single-cycle pulse in the cycle after a tlast transfer.
- `ready` is combinational: state==IDLE and resetn=1.
  - It is low throughout SHIFT and HOLD, so back-pressure on tready holds it low.
- Trigger while not in IDLE:
  - The trigger is ignored (no restart, no data corruption).
  - overrun is set the next cycle.
- overrun clear:
  - clear_overrun clears overrun.
  - If an ignored trigger and clear_overrun occur in the same cycle, set wins.
- Trigger in the same cycle as the HOLD transfer is ignored and sets overrun. `ready` was low in that cycle.
- Latency, trigger cycle T:
  - cs_n low at T+1.
  - tvalid at T+1+2*SCK_HALF*DATA_WIDTH.
  - Defaults: T+97.

Test Plan:
- Default params; ADC model shifts 0x123456 on sdo, changing sdo on sck falling edges; tready=1; trigger once.
  - → exactly 24 sck rising edges while cs_n=0.
  - → cs_n low for 96 cycles.
  - → tdata=0x00123456 at T+97.
  - → ready back to 1 one cycle after the transfer.
- Model shifts 0xA5A5A5 → tdata=0xFFA5A5A5 (negative sign extension).
- packet_len=3, three triggers spaced 120 cycles, tready=1.
  - → tlast only on word 3.
  - → `last` pulses one cycle after the third transfer.
  - → a fourth word has tlast=0 and the counter restarted.
- tready=0 after the first word.
  - → tvalid stays 1 with tdata/tlast stable; ready=0.
  - → a trigger pulse in HOLD sets overrun=1 and the stored word is unchanged.
  - → clear_overrun clears overrun.
  - → tready=1 completes the transfer.
- Trigger pulse at bit 10 of SHIFT → ignored; overrun=1; resulting word correct.
- resetn=0 for one cycle at bit 12 of SHIFT.
  - → next cycle: sck=0, cs_n=1, tvalid=0, overrun=0.
  - → ready=1 after release.
  - → a fresh trigger yields a correct full word.
